// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM arbiter.
package mem_arbiter_pkg;

    // Records which master was granted the RAM in the previous cycle.
    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2,
        OWN_STORE = 2'd3
    } own_e;

    // RAM access size codes.
    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    // Consecutive data grants tolerated while fetch waits.
    localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating counter of consecutive data grants taken while fetch waits.
module mem_arb_starve_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int unsigned CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    // Fetch must be granted once the count reaches the limit.
    always_comb begin
        at_max = (cnt == CNT_W'(STARVE_MAX));
    end

    // Clear wins over increment; the count holds once it saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store.
// Data has priority; a starvation counter forces a fetch grant periodically.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_valid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_re_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [2:0]        d_size_i,
    output logic              d_gnt_o,
    output logic              d_valid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic [2:0]        ram_size_o,
    output logic              ram_we_o,
    output logic              ram_re_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              hold_if_o
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    own_e             own_q;
    own_e             own_d;
    logic             d_req;
    logic             starve_at_max;
    logic [CNT_W-1:0] starve_cnt;

    assign d_req     = d_re_i | d_we_i;
    assign hold_if_o = if_req_i & ~if_gnt_o;

    mem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_starve_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (if_gnt_o | ~if_req_i),
        .inc    (d_gnt_o & if_req_i),
        .cnt    (starve_cnt),
        .at_max (starve_at_max)
    );

    // Grant: data first unless fetch has waited STARVE_MAX grants; none in reset.
    always_comb begin
        if_gnt_o = 1'b0;
        d_gnt_o  = 1'b0;
        if (!rst) begin
            if (d_req && !(if_req_i && starve_at_max)) begin
                d_gnt_o = 1'b1;
            end else if (if_req_i) begin
                if_gnt_o = 1'b1;
            end
        end
    end

    // RAM drive follows the grant; everything idles at zero otherwise.
    always_comb begin
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_size_o  = '0;
        ram_we_o    = 1'b0;
        ram_re_o    = 1'b0;
        if (if_gnt_o) begin
            ram_addr_o = if_addr_i;
            ram_size_o = SIZE_WORD;
            ram_re_o   = 1'b1;
        end else if (d_gnt_o) begin
            ram_addr_o  = d_addr_i;
            ram_wdata_o = d_wdata_i;
            ram_size_o  = d_size_i;
            ram_we_o    = d_we_i;
            ram_re_o    = d_re_i & ~d_we_i;
        end
    end

    // Owner register: remembers this cycle's grant for next cycle's response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_q <= OWN_IDLE;
        end else begin
            own_q <= own_d;
        end
    end

    // Next owner from the grant; responses decoded from the current owner.
    always_comb begin
        own_d      = OWN_IDLE;
        if_valid_o = 1'b0;
        if_rdata_o = '0;
        d_valid_o  = 1'b0;
        d_rdata_o  = '0;

        if (if_gnt_o) begin
            own_d = OWN_FETCH;
        end else if (d_gnt_o) begin
            own_d = d_we_i ? OWN_STORE : OWN_LOAD;
        end

        case (own_q)
            OWN_FETCH: begin
                if_valid_o = 1'b1;
                if_rdata_o = ram_rdata_i;
            end
            OWN_LOAD: begin
                d_valid_o = 1'b1;
                d_rdata_o = ram_rdata_i;
            end
            OWN_STORE: begin
                d_valid_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_re;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_size;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [2:0]        ram_size;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;
    logic              hold_if;

    logic              init_en;
    logic [31:0]       mem [0:255];

    int passed = 0;
    int total  = 0;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_valid_o  (if_valid),
        .if_rdata_o  (if_rdata),
        .d_re_i      (d_re),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_size_i    (d_size),
        .d_gnt_o     (d_gnt),
        .d_valid_o   (d_valid),
        .d_rdata_o   (d_rdata),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_size_o  (ram_size),
        .ram_we_o    (ram_we),
        .ram_re_o    (ram_re),
        .ram_rdata_i (ram_rdata),
        .hold_if_o   (hold_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents: words 0..2 hold 0x13 (nop), word i otherwise 0x1000_0000+i.
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= (i < 3) ? 32'h0000_0013 : 32'h1000_0000 + 32'(i);
            end
            ram_rdata <= '0;
        end else begin
            if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
            if (ram_re) ram_rdata <= mem[ram_addr[9:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_re;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [2:0]  d_size;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_hold;
        logic        e_ram_re;
        logic        e_ram_we;
        logic [31:0] e_ram_addr;
        logic [31:0] e_ram_wdata;
        logic [2:0]  e_ram_size;
        logic        e_if_valid;
        logic [31:0] e_if_rdata;
        logic        e_d_valid;
        logic [31:0] e_d_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] dwd, input logic [2:0] ds,
        input logic eig, input logic edg, input logic eh, input logic ere, input logic ewe,
        input logic [31:0] ea, input logic [31:0] ewd, input logic [2:0] es,
        input logic eiv, input logic [31:0] eir, input logic edv, input logic [31:0] edr);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.d_re = dr; v.d_we = dw;
        v.d_addr = da; v.d_wdata = dwd; v.d_size = ds;
        v.e_if_gnt = eig; v.e_d_gnt = edg; v.e_hold = eh; v.e_ram_re = ere; v.e_ram_we = ewe;
        v.e_ram_addr = ea; v.e_ram_wdata = ewd; v.e_ram_size = es;
        v.e_if_valid = eiv; v.e_if_rdata = eir; v.e_d_valid = edv; v.e_d_rdata = edr;
        return v;
    endfunction

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dwd, input logic [2:0] ds);
        if_req = ir; if_addr = ia; d_re = dr; d_we = dw;
        d_addr = da; d_wdata = dwd; d_size = ds;
    endtask

    initial begin
        rst = 1'b1;
        init_en = 1'b1;
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);

        // Fetch only: three back-to-back word fetches, then drain.
        vecs.push_back(mk(1,32'h00, 0,0,32'h0,32'h0,3'b000, 1,0,0,1,0,32'h00,32'h0,3'b010, 0,32'h0,        0,32'h0));
        vecs.push_back(mk(1,32'h04, 0,0,32'h0,32'h0,3'b000, 1,0,0,1,0,32'h04,32'h0,3'b010, 1,32'h13,       0,32'h0));
        vecs.push_back(mk(1,32'h08, 0,0,32'h0,32'h0,3'b000, 1,0,0,1,0,32'h08,32'h0,3'b010, 1,32'h13,       0,32'h0));
        vecs.push_back(mk(0,32'h00, 0,0,32'h0,32'h0,3'b000, 0,0,0,0,0,32'h00,32'h0,3'b000, 1,32'h13,       0,32'h0));
        // Three idle cycles.
        vecs.push_back(mk(0,32'h00, 0,0,32'h0,32'h0,3'b000, 0,0,0,0,0,32'h00,32'h0,3'b000, 0,32'h0,        0,32'h0));
        vecs.push_back(mk(0,32'h00, 0,0,32'h0,32'h0,3'b000, 0,0,0,0,0,32'h00,32'h0,3'b000, 0,32'h0,        0,32'h0));
        vecs.push_back(mk(0,32'h00, 0,0,32'h0,32'h0,3'b000, 0,0,0,0,0,32'h00,32'h0,3'b000, 0,32'h0,        0,32'h0));
        // Collision: load wins, fetch stalls, then fetch granted as load returns.
        vecs.push_back(mk(1,32'h0C, 1,0,32'h100,32'h0,3'b010, 0,1,1,1,0,32'h100,32'h0,3'b010, 0,32'h0,     0,32'h0));
        vecs.push_back(mk(1,32'h0C, 0,0,32'h0,32'h0,3'b000, 1,0,0,1,0,32'h0C,32'h0,3'b010, 0,32'h0,        1,32'h1000_0040));
        vecs.push_back(mk(0,32'h00, 0,0,32'h0,32'h0,3'b000, 0,0,0,0,0,32'h00,32'h0,3'b000, 1,32'h1000_0003, 0,32'h0));
        // Store then load of the same word.
        vecs.push_back(mk(0,32'h00, 0,1,32'h200,32'hDEADBEEF,3'b010, 0,1,0,0,1,32'h200,32'hDEADBEEF,3'b010, 0,32'h0, 0,32'h0));
        vecs.push_back(mk(0,32'h00, 1,0,32'h200,32'h0,3'b010, 0,1,0,1,0,32'h200,32'h0,3'b010, 0,32'h0,     1,32'h0));
        vecs.push_back(mk(0,32'h00, 0,0,32'h0,32'h0,3'b000, 0,0,0,0,0,32'h00,32'h0,3'b000, 0,32'h0,        1,32'hDEADBEEF));
        // re and we together act as a byte store; size passes through.
        vecs.push_back(mk(0,32'h00, 1,1,32'h204,32'h12345678,3'b000, 0,1,0,0,1,32'h204,32'h12345678,3'b000, 0,32'h0, 0,32'h0));
        vecs.push_back(mk(0,32'h00, 1,0,32'h204,32'h0,3'b010, 0,1,0,1,0,32'h204,32'h0,3'b010, 0,32'h0,     1,32'h0));
        vecs.push_back(mk(0,32'h00, 0,0,32'h0,32'h0,3'b000, 0,0,0,0,0,32'h00,32'h0,3'b000, 0,32'h0,        1,32'h12345678));

        // Reset state while a fetch request is pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.if_gnt",   32'(if_gnt),   32'h0);
        chk("rst.ram_re",   32'(ram_re),   32'h0);
        chk("rst.hold_if",  32'(hold_if),  32'h1);
        chk("rst.if_valid", 32'(if_valid), 32'h0);
        chk("rst.d_valid",  32'(d_valid),  32'h0);
        chk("rst.cnt",      32'(dut.starve_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        init_en = 1'b0;

        foreach (vecs[k]) begin
            drive(vecs[k].if_req, vecs[k].if_addr, vecs[k].d_re, vecs[k].d_we,
                  vecs[k].d_addr, vecs[k].d_wdata, vecs[k].d_size);
            @(negedge clk);
            chk($sformatf("v%0d.if_gnt", k),   32'(if_gnt),   32'(vecs[k].e_if_gnt));
            chk($sformatf("v%0d.d_gnt", k),    32'(d_gnt),    32'(vecs[k].e_d_gnt));
            chk($sformatf("v%0d.hold_if", k),  32'(hold_if),  32'(vecs[k].e_hold));
            chk($sformatf("v%0d.ram_re", k),   32'(ram_re),   32'(vecs[k].e_ram_re));
            chk($sformatf("v%0d.ram_we", k),   32'(ram_we),   32'(vecs[k].e_ram_we));
            chk($sformatf("v%0d.ram_addr", k), ram_addr,      vecs[k].e_ram_addr);
            chk($sformatf("v%0d.ram_size", k), 32'(ram_size), 32'(vecs[k].e_ram_size));
            if (!vecs[k].e_if_gnt)
                chk($sformatf("v%0d.ram_wdata", k), ram_wdata, vecs[k].e_ram_wdata);
            chk($sformatf("v%0d.if_valid", k), 32'(if_valid), 32'(vecs[k].e_if_valid));
            chk($sformatf("v%0d.if_rdata", k), if_rdata,      vecs[k].e_if_rdata);
            chk($sformatf("v%0d.d_valid", k),  32'(d_valid),  32'(vecs[k].e_d_valid));
            chk($sformatf("v%0d.d_rdata", k),  d_rdata,       vecs[k].e_d_rdata);
            @(posedge clk);
            #1;
        end

        // Starvation: both held for 6 cycles; fetch forced in cycle 5.
        begin
            logic [5:0] exp_d;
            exp_d = 6'b101111;
            for (int c = 0; c < 6; c++) begin
                drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0, 3'b010);
                @(negedge clk);
                chk($sformatf("starve%0d.d_gnt", c + 1),  32'(d_gnt),  32'(exp_d[c]));
                chk($sformatf("starve%0d.if_gnt", c + 1), 32'(if_gnt), 32'(!exp_d[c]));
                if (c == 4) chk("starve5.cnt", 32'(dut.starve_cnt), 32'd4);
                if (c == 5) begin
                    chk("starve6.cnt",      32'(dut.starve_cnt), 32'd0);
                    chk("starve6.if_valid", 32'(if_valid),       32'h1);
                    chk("starve6.if_rdata", if_rdata,            32'h1000_0004);
                end
                @(posedge clk);
                #1;
            end
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
            @(negedge clk);
            chk("starve7.cnt",     32'(dut.starve_cnt), 32'd1);
            chk("starve7.d_valid", 32'(d_valid),        32'h1);
            chk("starve7.d_rdata", d_rdata,             32'h1000_0010);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("starve8.cnt", 32'(dut.starve_cnt), 32'd0);
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a load with a nonzero starvation count.
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 3'b010);
        @(negedge clk);
        chk("mid.d_gnt0", 32'(d_gnt), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid.d_gnt1",   32'(d_gnt),   32'h1);
        chk("mid.d_valid1", 32'(d_valid), 32'h1);
        chk("mid.cnt1",     32'(dut.starve_cnt), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid.rst_d_valid", 32'(d_valid), 32'h0);
        chk("mid.rst_d_rdata", d_rdata,      32'h0);
        chk("mid.rst_d_gnt",   32'(d_gnt),   32'h0);
        chk("mid.rst_ram_re",  32'(ram_re),  32'h0);
        chk("mid.rst_hold",    32'(hold_if), 32'h1);
        chk("mid.rst_cnt",     32'(dut.starve_cnt), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid.rst2_d_valid", 32'(d_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("post%0d.d_valid", c),  32'(d_valid),  32'h0);
            chk($sformatf("post%0d.if_valid", c), 32'(if_valid), 32'h0);
            chk($sformatf("post%0d.cnt", c),      32'(dut.starve_cnt), 32'd0);
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
